// File: rtl/dpram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// dpram_fifo_ctrl
//
// Purpose:
//   Single-clock FIFO controller in front of an external 2**ADDR_W x DATA_W
//   dual-port RAM (port A = synchronous write, port B = registered read).
//   Bytes accepted on the upstream valid/ready stream are written through
//   port A. They are fetched back through port B into a 2-entry output skid
//   buffer and presented in order on the downstream valid/ready stream.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream byte valid
//   in_ready   out  controller can accept a byte (low while in reset or RAM full)
//   in_data    in   upstream byte
//   out_valid  out  out_data holds a valid byte
//   out_ready  in   downstream accepts out_data
//   out_data   out  head-of-FIFO byte
//   data_a     out  RAM port A write data (= in_data)
//   addr_a     out  RAM port A address (= write pointer)
//   we_a       out  RAM port A write enable
//   data_b     out  RAM port B write data (tied to 0)
//   addr_b     out  RAM port B address (= read pointer)
//   we_b       out  RAM port B write enable (tied to 0)
//   q_b        in   RAM port B read data, valid the cycle after addr_b sampled
//
// Optional build macro DPRAM_FIFO_LEVEL_EN adds:
//   level       out  registered total occupancy (RAM + in-flight + buffer)
//   almost_full out  registered, level >= DEPTH-4
// ---------------------------------------------------------------------------
module dpram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] data_a,
    output logic [ADDR_W-1:0] addr_a,
    output logic              we_a,
    output logic [DATA_W-1:0] data_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic              we_b,
    input  logic [DATA_W-1:0] q_b
`ifdef DPRAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W+1:0] level,
    output logic              almost_full
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_mem_cnt;
    logic              r_rd_pend;
    logic [1:0]        r_buf_cnt;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;

    logic              w_push;
    logic              w_pop;
    logic              w_rd_go;
    logic [2:0]        w_occ;
    logic [ADDR_W:0]   w_mem_cnt_nxt;
    logic [1:0]        w_buf_cnt_nxt;
    logic [DATA_W-1:0] w_buf0_nxt;
    logic [DATA_W-1:0] w_buf1_nxt;

    // in_ready is qualified by rst_n so nothing is written while reset is held
    assign in_ready  = rst_n && (r_mem_cnt != DEPTH_C);
    assign w_push    = in_valid && in_ready;
    assign we_a      = w_push;
    assign data_a    = in_data;
    assign addr_a    = r_wr_ptr;
    assign data_b    = {DATA_W{1'b0}};
    assign we_b      = 1'b0;
    assign addr_b    = r_rd_ptr;
    assign out_valid = (r_buf_cnt != 2'd0);
    assign out_data  = r_buf0;
    assign w_pop     = out_valid && out_ready;

    // Read issue and next-state computation for counters and skid buffer
    always_comb begin
        w_mem_cnt_nxt = r_mem_cnt;
        w_buf_cnt_nxt = r_buf_cnt;
        w_buf0_nxt    = r_buf0;
        w_buf1_nxt    = r_buf1;

        // Slots committed to the buffer after this edge: held + in flight - leaving.
        // A new fetch is only issued if its return is guaranteed a free slot.
        w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
        w_rd_go = (r_mem_cnt != {(ADDR_W + 1){1'b0}}) && (w_occ < 3'd2);

        case ({w_push, w_rd_go})
            2'b10:   w_mem_cnt_nxt = r_mem_cnt + (ADDR_W + 1)'(1);
            2'b01:   w_mem_cnt_nxt = r_mem_cnt - (ADDR_W + 1)'(1);
            default: w_mem_cnt_nxt = r_mem_cnt;
        endcase

        // buf0 is always the head; a returning byte lands at the tail
        case ({w_pop, r_rd_pend})
            2'b10: begin
                w_buf0_nxt    = r_buf1;
                w_buf_cnt_nxt = r_buf_cnt - 2'd1;
            end
            2'b01: begin
                if (r_buf_cnt == 2'd0) begin
                    w_buf0_nxt = q_b;
                end else begin
                    w_buf1_nxt = q_b;
                end
                w_buf_cnt_nxt = r_buf_cnt + 2'd1;
            end
            2'b11: begin
                if (r_buf_cnt == 2'd1) begin
                    w_buf0_nxt = q_b;
                end else begin
                    w_buf0_nxt = r_buf1;
                    w_buf1_nxt = q_b;
                end
                w_buf_cnt_nxt = r_buf_cnt;
            end
            default: begin
                w_buf_cnt_nxt = r_buf_cnt;
            end
        endcase
    end

    // Pointer, counter, read-pending and skid buffer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= {ADDR_W{1'b0}};
            r_rd_ptr  <= {ADDR_W{1'b0}};
            r_mem_cnt <= {(ADDR_W + 1){1'b0}};
            r_rd_pend <= 1'b0;
            r_buf_cnt <= 2'd0;
            r_buf0    <= {DATA_W{1'b0}};
            r_buf1    <= {DATA_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_go) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_mem_cnt <= w_mem_cnt_nxt;
            r_rd_pend <= w_rd_go;
            r_buf_cnt <= w_buf_cnt_nxt;
            r_buf0    <= w_buf0_nxt;
            r_buf1    <= w_buf1_nxt;
        end
    end

`ifdef DPRAM_FIFO_LEVEL_EN
    logic [ADDR_W+1:0] w_level_nxt;
    logic [ADDR_W+1:0] r_level;
    logic              r_almost_full;

    // Level is built from next-state values so it matches the state it describes
    always_comb begin
        w_level_nxt = (ADDR_W + 2)'(w_mem_cnt_nxt) + (ADDR_W + 2)'(w_rd_go)
                    + (ADDR_W + 2)'(w_buf_cnt_nxt);
    end

    // Registered occupancy and almost-full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level       <= {(ADDR_W + 2){1'b0}};
            r_almost_full <= 1'b0;
        end else begin
            r_level       <= w_level_nxt;
            r_almost_full <= (w_level_nxt >= (ADDR_W + 2)'(DEPTH - 4));
        end
    end

    assign level       = r_level;
    assign almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
module tb_dpram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] data_a;
    logic [5:0] addr_a;
    logic       we_a;
    logic [7:0] data_b;
    logic [5:0] addr_b;
    logic       we_b;
    logic [7:0] q_b;
`ifdef DPRAM_FIFO_LEVEL_EN
    logic [7:0] level;
    logic       almost_full;
`endif

    dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .data_a(data_a), .addr_a(addr_a), .we_a(we_a),
        .data_b(data_b), .addr_b(addr_b), .we_b(we_b), .q_b(q_b)
`ifdef DPRAM_FIFO_LEVEL_EN
        , .level(level), .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    // External RAM: synchronous write on A, registered read on B
    logic [7:0] ram [0:63];
    always @(posedge clk) begin
        if (we_a) ram[addr_a] <= data_a;
        q_b <= ram[addr_b];
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_pop = 0;
    logic [7:0] sb [$];
    int pop_cyc [$];
    logic [5:0] exp_wr = 6'd0;
    logic [5:0] prev_a = 6'd0;
    logic [5:0] prev_b = 6'd0;
    bit a_wrap = 1'b0;
    bit b_wrap = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: sample handshakes at the falling edge, then advance.
    task automatic tick();
        logic hs_in;
        @(negedge clk);
`ifdef DPRAM_FIFO_LEVEL_EN
        chk("level", level, sb.size());
        chk("almost_full", almost_full, (sb.size() >= 60));
`endif
        chk("we_b", we_b, 1'b0);
        chk("data_b", data_b, 8'h00);
        hs_in = in_valid && in_ready;
        chk("we_a", we_a, hs_in);
        if (hs_in) begin
            chk("addr_a", addr_a, exp_wr);
            chk("data_a", data_a, in_data);
            if (prev_a == 6'h3F && addr_a == 6'h00) a_wrap = 1'b1;
            prev_a = addr_a;
            sb.push_back(in_data);
            exp_wr = exp_wr + 6'd1;
            n_acc++;
        end
        if (prev_b == 6'h3F && addr_b == 6'h00) b_wrap = 1'b1;
        prev_b = addr_b;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("pop_nonempty_sb", 32'd0, 32'd1);
            end else begin
                chk("out_data", out_data, sb.pop_front());
            end
            pop_cyc.push_back(cyc);
            n_pop++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 300 && (sb.size() != 0 || out_valid); i++) tick();
        chk(tag, sb.size(), 0);
        chk({tag, "_ov"}, out_valid, 1'b0);
    endtask

    initial begin
        int s;
        int acc0;
        int pop0;
        int sent;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_addr_a", addr_a, 6'h00);
        chk("rst_addr_b", addr_b, 6'h00);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1'b1);

        // Single write: 0x33 visible two edges after it is accepted
        in_valid = 1'b1; in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        chk("single_ov_e0", out_valid, 1'b0);
        tick();
        chk("single_ov_e1", out_valid, 1'b0);
        tick();
        chk("single_ov_e2", out_valid, 1'b1);
        chk("single_data", out_data, 8'h33);
        out_ready = 1'b1;
        tick();
        chk("single_after_pop", out_valid, 1'b0);

        // Streaming 0x00..0x0F at one byte per cycle
        pop_cyc.delete();
        s = cyc;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && pop_cyc.size() < 16; i++) tick();
        chk("stream_count", pop_cyc.size(), 16);
        if (pop_cyc.size() == 16) begin
            chk("stream_latency", pop_cyc[0], s + 3);
            chk("stream_no_gaps", pop_cyc[15] - pop_cyc[0], 15);
        end

        // Fill: exactly DEPTH+2 accepted under backpressure
        out_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 80; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 8'h40);
            tick();
        end
        chk("fill_accepted", n_acc - acc0, 66);
        chk("fill_in_ready", in_ready, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        pop0 = n_pop;
        tick();
        chk("fill_in_ready_back", in_ready, 1'b1);
        drain("fill_drain");
        chk("fill_popped", n_pop - pop0, 66);

        // Wrap: 130 bytes with random backpressure
        sent = 0;
        for (int i = 0; i < 3000 && sent < 130; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 1));
            if (in_ready) sent++;
            tick();
        end
        chk("wrap_sent", sent, 130);
        drain("wrap_drain");
        chk("wrap_addr_a", a_wrap, 1'b1);
        chk("wrap_addr_b", b_wrap, 1'b1);

        // Async reset with 5 bytes queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hA0 + i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("pre_rst_ov", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ov", out_valid, 1'b0);
        chk("async_rst_ir", in_ready, 1'b0);
        chk("async_rst_data", out_data, 8'h00);
        sb.delete();
        exp_wr = 6'd0; prev_a = 6'd0; prev_b = 6'd0;
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        chk("in_rst_we_a", we_a, 1'b0);
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        chk("rst_first_ov", out_valid, 1'b1);
        chk("rst_first_data", out_data, 8'h77);
        drain("rst_drain");

`ifdef DPRAM_FIFO_LEVEL_EN
        // Level / almost_full under backpressure, then one pop at a time
        out_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("lvl_60", level, 60);
        chk("lvl_af", almost_full, 1'b1);
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("lvl_dec", level, 59 - i);
        end
        drain("lvl_drain");
        chk("lvl_empty", level, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
